// File: rtl/ec_point_add_dbl.sv
// Affine point addition / doubling over GF(p) for y^2 = x^3 + a*x + b.
// One shared modular multiplier; the inverse comes from a binary extended Euclid.
module ec_point_add_dbl #(
    parameter int N = 231
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mode,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] y1,
    input  logic         inf1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] y2,
    input  logic         inf2,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] x3,
    output logic [N-1:0] y3,
    output logic         inf3
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_NUMDEN,
        S_INV,
        S_LAMBDA,
        S_X3,
        S_Y3,
        S_DONE
    } state_t;

    localparam logic [N-1:0] ONE = N'(1);

    state_t r_state;
    state_t w_state_next;

    logic [N-1:0] r_p, r_a, r_x1, r_y1, r_x2, r_y2;
    logic         r_mode, r_inf1, r_inf2, r_dbl;
    logic [N-1:0] r_num, r_inv, r_lam;
    logic [N-1:0] r_u, r_v, r_g1, r_g2;
    logic [N-1:0] r_rx, r_ry;
    logic         r_rinf;
    logic         r_busy, r_done, r_inf3;
    logic [N-1:0] r_x3, r_y3;

    logic         w_sp, w_sp_inf, w_dbl;
    logic [N-1:0] w_sp_x, w_sp_y;
    logic [N-1:0] w_mul_a, w_mul_b, w_mul;
    logic [N-1:0] w_num_nd, w_den_nd;
    logic         w_inv_end;
    logic [N-1:0] w_u_n, w_v_n, w_g1_n, w_g2_n;

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] m);
        return (x >= y) ? (x - y) : (x - y + m);
    endfunction

    function automatic logic [N-1:0] mod_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] m);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m})
            s = s - {1'b0, m};
        return s[N-1:0];
    endfunction

    // x/2 mod m for odd m: add m first when x is odd so the shift is exact
    function automatic logic [N-1:0] mod_half(input logic [N-1:0] x, input logic [N-1:0] m);
        logic [N:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return s[N:1];
    endfunction

    // Special cases in priority order; equal points fall through to doubling
    always_comb begin
        w_sp     = 1'b0;
        w_sp_inf = 1'b0;
        w_sp_x   = '0;
        w_sp_y   = '0;
        w_dbl    = r_mode;
        if (r_mode) begin
            if (r_inf1 || r_y1 == '0) begin
                w_sp     = 1'b1;
                w_sp_inf = 1'b1;
            end
        end else if (r_inf1) begin
            w_sp     = 1'b1;
            w_sp_inf = r_inf2;
            w_sp_x   = r_inf2 ? '0 : r_x2;
            w_sp_y   = r_inf2 ? '0 : r_y2;
        end else if (r_inf2) begin
            w_sp   = 1'b1;
            w_sp_x = r_x1;
            w_sp_y = r_y1;
        end else if (r_x1 == r_x2) begin
            if (r_y1 != r_y2 || r_y1 == '0) begin
                w_sp     = 1'b1;
                w_sp_inf = 1'b1;
            end else begin
                w_dbl = 1'b1;
            end
        end
    end

    always_comb begin
        w_mul_a = r_lam;
        w_mul_b = r_lam;
        case (r_state)
            S_NUMDEN: begin
                w_mul_a = r_x1;
                w_mul_b = r_x1;
            end
            S_LAMBDA: begin
                w_mul_a = r_num;
                w_mul_b = r_inv;
            end
            S_Y3: begin
                w_mul_a = r_lam;
                w_mul_b = mod_sub(r_x1, r_rx, r_p);
            end
            default: ;
        endcase
    end

    assign w_mul = N'(({{N{1'b0}}, w_mul_a} * {{N{1'b0}}, w_mul_b}) % {{N{1'b0}}, r_p});

    assign w_num_nd = r_dbl ? mod_add(mod_add(mod_add(w_mul, w_mul, r_p), w_mul, r_p), r_a, r_p)
                            : mod_sub(r_y2, r_y1, r_p);
    assign w_den_nd = r_dbl ? mod_add(r_y1, r_y1, r_p) : mod_sub(r_x2, r_x1, r_p);

    // Invariants g1*den == u and g2*den == v (mod p); every step halves u or v
    assign w_inv_end = (r_u == ONE) || (r_v == ONE);

    always_comb begin
        w_u_n  = r_u;
        w_v_n  = r_v;
        w_g1_n = r_g1;
        w_g2_n = r_g2;
        if (!r_u[0]) begin
            w_u_n  = r_u >> 1;
            w_g1_n = mod_half(r_g1, r_p);
        end else if (!r_v[0]) begin
            w_v_n  = r_v >> 1;
            w_g2_n = mod_half(r_g2, r_p);
        end else if (r_u >= r_v) begin
            w_u_n  = (r_u - r_v) >> 1;
            w_g1_n = mod_half(mod_sub(r_g1, r_g2, r_p), r_p);
        end else begin
            w_v_n  = (r_v - r_u) >> 1;
            w_g2_n = mod_half(mod_sub(r_g2, r_g1, r_p), r_p);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_CHECK;
            S_CHECK:  w_state_next = w_sp ? S_DONE : S_NUMDEN;
            S_NUMDEN: w_state_next = S_INV;
            S_INV:    if (w_inv_end) w_state_next = S_LAMBDA;
            S_LAMBDA: w_state_next = S_X3;
            S_X3:     w_state_next = S_Y3;
            S_Y3:     w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_p    <= '0;
            r_a    <= '0;
            r_x1   <= '0;
            r_y1   <= '0;
            r_x2   <= '0;
            r_y2   <= '0;
            r_mode <= 1'b0;
            r_inf1 <= 1'b0;
            r_inf2 <= 1'b0;
            r_dbl  <= 1'b0;
            r_num  <= '0;
            r_inv  <= '0;
            r_lam  <= '0;
            r_u    <= '0;
            r_v    <= '0;
            r_g1   <= '0;
            r_g2   <= '0;
            r_rx   <= '0;
            r_ry   <= '0;
            r_rinf <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_p    <= p;
                        r_a    <= a;
                        r_mode <= mode;
                        r_x1   <= x1;
                        r_y1   <= y1;
                        r_inf1 <= inf1;
                        r_x2   <= x2;
                        r_y2   <= y2;
                        r_inf2 <= inf2;
                    end
                end
                S_CHECK: begin
                    r_dbl  <= w_dbl;
                    r_rx   <= w_sp_x;
                    r_ry   <= w_sp_y;
                    r_rinf <= w_sp_inf;
                end
                S_NUMDEN: begin
                    r_num <= w_num_nd;
                    r_u   <= w_den_nd;
                    r_v   <= r_p;
                    r_g1  <= ONE;
                    r_g2  <= '0;
                end
                S_INV: begin
                    if (w_inv_end) begin
                        r_inv <= (r_u == ONE) ? r_g1 : r_g2;
                    end else begin
                        r_u  <= w_u_n;
                        r_v  <= w_v_n;
                        r_g1 <= w_g1_n;
                        r_g2 <= w_g2_n;
                    end
                end
                S_LAMBDA: r_lam <= w_mul;
                S_X3:     r_rx  <= mod_sub(mod_sub(w_mul, r_x1, r_p), r_dbl ? r_x1 : r_x2, r_p);
                S_Y3: begin
                    r_ry   <= mod_sub(w_mul, r_y1, r_p);
                    r_rinf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs: done and the new result appear the cycle after DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_x3   <= '0;
            r_y3   <= '0;
            r_inf3 <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_IDLE && start)
                r_busy <= 1'b1;
            else if (r_state == S_DONE)
                r_busy <= 1'b0;
            if (r_state == S_DONE) begin
                r_x3   <= r_rx;
                r_y3   <= r_ry;
                r_inf3 <= r_rinf;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign x3   = r_x3;
    assign y3   = r_y3;
    assign inf3 = r_inf3;

endmodule

// File: tb/tb_ec_point_add_dbl.sv
// Directed and randomized checks of ec_point_add_dbl against a modular-arithmetic
// reference model (Fermat inverse, 64-bit integers, small primes).
module tb_ec_point_add_dbl;

    localparam int N       = 231;
    localparam int LAT_MAX = 2 * N + 8;
    localparam int LIMIT   = 2 * N + 40;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [N-1:0] p = '0, a = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic         inf1 = 1'b0, inf2 = 1'b0;
    logic         busy, done, inf3;
    logic [N-1:0] x3, y3;

    int checks = 0;
    int errors = 0;
    int lat;
    int ndone;
    longint unsigned ex, ey;
    bit einf;
    longint unsigned primes[5] = '{17, 97, 65521, 1000003, 2147483647};

    ec_point_add_dbl #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .p(p), .a(a), .x1(x1), .y1(y1), .inf1(inf1),
        .x2(x2), .y2(y2), .inf2(inf2),
        .busy(busy), .done(done), .x3(x3), .y3(y3), .inf3(inf3)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic longint unsigned mmul(input longint unsigned u, input longint unsigned v,
                                             input longint unsigned m);
        return (u * v) % m;
    endfunction

    function automatic longint unsigned msub(input longint unsigned u, input longint unsigned v,
                                             input longint unsigned m);
        return (u + m - v) % m;
    endfunction

    function automatic longint unsigned minv(input longint unsigned u, input longint unsigned m);
        longint unsigned r, b, e;
        r = 1; b = u % m; e = m - 2;
        while (e != 0) begin
            if (e[0]) r = mmul(r, b, m);
            b = mmul(b, b, m);
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic longint unsigned rnd(input longint unsigned m);
        longint unsigned r;
        r = $urandom;
        return r % m;
    endfunction

    task automatic ref_op(input bit m, input longint unsigned pp, input longint unsigned aa,
                          input longint unsigned xx1, input longint unsigned yy1, input bit i1,
                          input longint unsigned xx2, input longint unsigned yy2, input bit i2,
                          output longint unsigned rx, output longint unsigned ry,
                          output bit rinf, output bit sp);
        longint unsigned lam, other;
        bit dbl;
        rx = 0; ry = 0; rinf = 0; sp = 1; dbl = m;
        if (m) begin
            if (i1 || yy1 == 0) rinf = 1; else sp = 0;
        end else if (i1) begin
            rinf = i2; rx = i2 ? 0 : xx2; ry = i2 ? 0 : yy2;
        end else if (i2) begin
            rx = xx1; ry = yy1;
        end else if (xx1 == xx2) begin
            if (yy1 != yy2 || yy1 == 0) rinf = 1;
            else begin sp = 0; dbl = 1; end
        end else begin
            sp = 0;
        end
        if (!sp) begin
            if (dbl)
                lam = mmul((3 * mmul(xx1, xx1, pp) + aa) % pp, minv((2 * yy1) % pp, pp), pp);
            else
                lam = mmul(msub(yy2, yy1, pp), minv(msub(xx2, xx1, pp), pp), pp);
            other = dbl ? xx1 : xx2;
            rx = msub(msub(mmul(lam, lam, pp), xx1, pp), other, pp);
            ry = msub(mmul(lam, msub(xx1, rx, pp), pp), yy1, pp);
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation, scrambles the inputs while busy, optionally pulses a
    // second start at lat == extra_at, and waits (bounded) for done.
    task automatic run_op(input bit m, input longint unsigned pp, input longint unsigned aa,
                          input longint unsigned xx1, input longint unsigned yy1, input bit i1,
                          input longint unsigned xx2, input longint unsigned yy2, input bit i2,
                          input int extra_at);
        @(negedge clk);
        chk("done_low_between_ops", N'(done), N'(0));
        mode = m; p = N'(pp); a = N'(aa);
        x1 = N'(xx1); y1 = N'(yy1); inf1 = i1;
        x2 = N'(xx2); y2 = N'(yy2); inf2 = i2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x1 = N'($urandom); y1 = N'($urandom); x2 = N'($urandom); y2 = N'($urandom);
        a = N'($urandom); inf1 = ~i1; inf2 = ~i2;
        chk("busy_after_start", N'(busy), N'(1));
        lat = 1;
        while (done !== 1'b1 && lat < LIMIT) begin
            if (lat == extra_at) begin
                start = 1'b1; mode = ~m; x1 = N'($urandom); y1 = N'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("done_seen", N'(done), N'(1));
        chk("busy_low_at_done", N'(busy), N'(0));
    endtask

    task automatic do_op(input string tag, input bit m, input longint unsigned pp,
                         input longint unsigned aa, input longint unsigned xx1,
                         input longint unsigned yy1, input bit i1, input longint unsigned xx2,
                         input longint unsigned yy2, input bit i2, input int extra_at);
        bit sp;
        run_op(m, pp, aa, xx1, yy1, i1, xx2, yy2, i2, extra_at);
        ref_op(m, pp, aa, xx1, yy1, i1, xx2, yy2, i2, ex, ey, einf, sp);
        chk({tag, "_x3"}, x3, N'(ex));
        chk({tag, "_y3"}, y3, N'(ey));
        chk({tag, "_inf3"}, N'(inf3), N'(einf));
        if (sp) chk({tag, "_lat_special"}, N'(lat), N'(3));
        else    chk({tag, "_lat_bound"}, N'(lat <= LAT_MAX), N'(1));
        $display("op %s mode=%0d p=%0d P1=(%0d,%0d,%0d) P2=(%0d,%0d,%0d) -> (%0d,%0d,%0d) lat=%0d",
                 tag, m, pp, xx1, yy1, i1, xx2, yy2, i2, x3, y3, inf3, lat);
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_done", N'(done), N'(0));
        chk("rst_x3", x3, N'(0));
        chk("rst_y3", y3, N'(0));
        chk("rst_inf3", N'(inf3), N'(0));
        reset = 1'b1;

        do_op("dbl", 1, 17, 2, 5, 1, 0, 0, 0, 0, 0);
        chk("dbl_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd6, 8'd3, 8'd0});
        do_op("add1", 0, 17, 2, 5, 1, 0, 6, 3, 0, 0);
        chk("add1_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd10, 8'd6, 8'd0});
        do_op("add2", 0, 17, 2, 10, 6, 0, 5, 1, 0, 0);
        chk("add2_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd3, 8'd1, 8'd0});
        do_op("invpair", 0, 17, 2, 5, 1, 0, 5, 16, 0, 0);
        chk("invpair_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd0, 8'd0, 8'd1});
        do_op("inf1_add", 0, 17, 2, 9, 9, 1, 5, 1, 0, 0);
        chk("inf1_add_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd5, 8'd1, 8'd0});
        do_op("eqadd", 0, 17, 2, 5, 1, 0, 5, 1, 0, 0);
        chk("eqadd_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd6, 8'd3, 8'd0});
        do_op("dbl_inf", 1, 17, 2, 5, 1, 1, 0, 0, 0, 0);
        chk("dbl_inf_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd0, 8'd0, 8'd1});
        do_op("dbl_pre_reset", 1, 17, 2, 5, 1, 0, 0, 0, 0, 0);

        // Reset in the middle of a doubling: no done, outputs cleared
        @(negedge clk);
        mode = 1'b1; p = N'(17); a = N'(2); x1 = N'(5); y1 = N'(1); inf1 = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_busy", N'(busy), N'(0));
        chk("midrst_done", N'(done), N'(0));
        chk("midrst_x3", x3, N'(0));
        chk("midrst_y3", y3, N'(0));
        chk("midrst_inf3", N'(inf3), N'(0));
        ndone = 0;
        repeat (LIMIT) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("midrst_no_done", N'(ndone), N'(0));
        do_op("after_rst", 0, 17, 2, 6, 3, 0, 5, 1, 0, 0);
        chk("after_rst_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd10, 8'd6, 8'd0});

        // Second start while busy must be ignored
        do_op("ignored_start", 0, 17, 2, 5, 1, 0, 6, 3, 0, 5);
        chk("ignored_start_const", {x3[7:0], y3[7:0], 7'd0, inf3}, {8'd10, 8'd6, 8'd0});
        ndone = 0;
        repeat (LIMIT) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        chk("ignored_start_no_second_op", N'(ndone), N'(0));

        for (int i = 0; i < 24; i++) begin
            longint unsigned pp, aa, xx1, yy1, xx2, yy2;
            bit m, i1, i2;
            pp = primes[$urandom_range(0, 4)];
            aa = rnd(pp); xx1 = rnd(pp); yy1 = rnd(pp); xx2 = rnd(pp); yy2 = rnd(pp);
            m = 1'($urandom_range(0, 1)); i1 = 1'b0; i2 = 1'b0;
            case ($urandom_range(0, 9))
                0: i1 = 1'b1;
                1: i2 = 1'b1;
                2: begin xx2 = xx1; yy2 = yy1; end
                3: begin xx2 = xx1; yy2 = (pp - yy1) % pp; end
                4: yy1 = 0;
                default: ;
            endcase
            do_op("rnd", m, pp, aa, xx1, yy1, i1, xx2, yy2, i2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
